// File: rtl/pipe_pkg.sv
// Shared pipeline constants and shadow-stage type for the redirect (hazard/forwarding) controller.
package pipe_pkg;

  localparam int unsigned SHADOW_AW = 5;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_LUI = 6'h0f;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_WBDLY = 2'b11;

  typedef struct packed {
    logic                 we;
    logic [SHADOW_AW-1:0] wreg;
    logic                 is_load;
  } shadow_t;

  // r0 is hard-wired zero, so a write to it never produces a value worth forwarding.
  function automatic logic writes(input shadow_t s, input logic [SHADOW_AW-1:0] r);
    return s.we && (s.wreg == r) && (r != '0);
  endfunction

endpackage

// File: rtl/fwd_pick.sv
// Nearest-producer-first forwarding select for one EX operand.
module fwd_pick
  import pipe_pkg::*;
(
  input  logic [SHADOW_AW-1:0] src,
  input  logic                 use_src,
  input  shadow_t              ex,
  input  shadow_t              mem,
  input  shadow_t              wb,
  output logic [1:0]           sel
);

  always_comb begin
    sel = FWD_RF;
    if (use_src) begin
      if (writes(ex, src)) begin
        sel = FWD_EXMEM;
      end else if (writes(mem, src)) begin
        sel = FWD_MEMWB;
      end else if (writes(wb, src)) begin
        sel = FWD_WBDLY;
      end
    end
  end

endmodule

// File: rtl/redirect_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline; REG_AW must match SHADOW_AW.
// Optional counters (stall_cnt, fwd_cnt, flush_cnt) are built when REDIRECT_STATS_EN is defined.
module redirect_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_op,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_wreg,
  input  logic              id_regwrite,
  input  logic              flush,
  input  logic              mem_stall,
  output logic              stall,
  output logic              bubble,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_wreg
`ifdef REDIRECT_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  shadow_t    ex_q, mem_q, wb_q;
  shadow_t    id_sh;
  logic       is_load;
  logic       hazard;
  logic [1:0] pick_a, pick_b;

  always_comb begin
    is_load      = (id_op == OP_W'(OP_LW)) || (id_op == OP_W'(OP_LBU));
    id_sh.we      = id_regwrite;
    id_sh.wreg    = id_wreg;
    id_sh.is_load = is_load;
    hazard = id_valid && ex_q.is_load &&
             ((id_use_rs && writes(ex_q, id_rs)) || (id_use_rt && writes(ex_q, id_rt)));
    stall  = hazard && !flush && !mem_stall;
    // The external freeze dominates; reset also masks the empty-ID bubble.
    bubble = (hazard || flush || !id_valid) && !mem_stall && !rst;
  end

  fwd_pick u_pick_a (
    .src     (id_rs),
    .use_src (id_use_rs),
    .ex      (ex_q),
    .mem     (mem_q),
    .wb      (wb_q),
    .sel     (pick_a)
  );

  fwd_pick u_pick_b (
    .src     (id_rt),
    .use_src (id_use_rt),
    .ex      (ex_q),
    .mem     (mem_q),
    .wb      (wb_q),
    .sel     (pick_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
    end else if (!mem_stall) begin
      ex_q      <= bubble ? '0 : id_sh;
      mem_q     <= ex_q;
      wb_q      <= mem_q;
      fwd_a_sel <= bubble ? FWD_RF : pick_a;
      fwd_b_sel <= bubble ? FWD_RF : pick_b;
    end
  end

  assign wb_we   = wb_q.we;
  assign wb_wreg = wb_q.wreg;

`ifdef REDIRECT_STATS_EN
  logic fwd_entry;
  assign fwd_entry = !mem_stall && !bubble && ((pick_a != FWD_RF) || (pick_b != FWD_RF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall)              stall_cnt <= stall_cnt + 32'd1;
      if (fwd_entry)          fwd_cnt   <= fwd_cnt + 32'd1;
      if (flush && !mem_stall) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed self-checking bench for redirect_ctrl (stats checks when REDIRECT_STATS_EN is defined).
module tb_redirect_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [5:0] id_op = '0;
  logic [4:0] id_rs = '0, id_rt = '0, id_wreg = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_regwrite = 1'b0;
  logic       flush = 1'b0, mem_stall = 1'b0;
  logic       stall, bubble, wb_we;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [4:0] wb_wreg;
`ifdef REDIRECT_STATS_EN
  logic [31:0] stall_cnt, fwd_cnt, flush_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  redirect_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_op       (id_op),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_wreg     (id_wreg),
    .id_regwrite (id_regwrite),
    .flush       (flush),
    .mem_stall   (mem_stall),
    .stall       (stall),
    .bubble      (bubble),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .wb_we       (wb_we),
    .wb_wreg     (wb_wreg)
`ifdef REDIRECT_STATS_EN
    ,
    .stall_cnt   (stall_cnt),
    .fwd_cnt     (fwd_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  // Present one ID-stage instruction just after the falling edge.
  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urs, input logic urt,
                       input logic [4:0] wr, input logic rw);
    @(negedge clk);
    id_valid = v; id_op = op; id_rs = rs; id_rt = rt;
    id_use_rs = urs; id_use_rt = urt; id_wreg = wr; id_regwrite = rw;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    flush = 1'b0; mem_stall = 1'b0;
    id_valid = 1'b0; id_op = '0; id_rs = '0; id_rt = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_wreg = '0; id_regwrite = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %0b exp 0", stall); end
    checks++; if (bubble !== 1'b0) begin fails++; $display("FAIL reset_bubble got %0b exp 0", bubble); end
    checks++; if (fwd_a_sel !== 2'b00) begin fails++; $display("FAIL reset_fwd_a got %b exp 00", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b00) begin fails++; $display("FAIL reset_fwd_b got %b exp 00", fwd_b_sel); end
    checks++; if (wb_we !== 1'b0) begin fails++; $display("FAIL reset_wb_we got %0b exp 0", wb_we); end
    checks++; if (wb_wreg !== 5'd0) begin fails++; $display("FAIL reset_wb_wreg got %0d exp 0", wb_wreg); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    apply_reset();
    drive(1, 6'h00, 5'd1, 5'd2, 1, 1, 5'd3, 1);   // add r3,r1,r2
    tick();
    drive(1, 6'h00, 5'd3, 5'd1, 1, 1, 5'd4, 1);   // add r4,r3,r1
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL b2b_stall got %0b exp 0", stall); end
    checks++; if (bubble !== 1'b0) begin fails++; $display("FAIL b2b_bubble got %0b exp 0", bubble); end
    tick();
    checks++; if (fwd_a_sel !== 2'b01) begin fails++; $display("FAIL b2b_fwd_a got %b exp 01", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b00) begin fails++; $display("FAIL b2b_fwd_b got %b exp 00", fwd_b_sel); end
    drive(0, 6'h00, 5'd0, 5'd0, 0, 0, 5'd0, 0);
    checks++; if (bubble !== 1'b1) begin fails++; $display("FAIL b2b_idle_bubble got %0b exp 1", bubble); end
    tick();
  endtask

  task automatic test_load_use;
    apply_reset();
    drive(1, 6'h23, 5'd1, 5'd0, 1, 0, 5'd5, 1);   // lw r5
    tick();
    drive(1, 6'h00, 5'd5, 5'd2, 1, 1, 5'd6, 1);   // add r6,r5,r2
    checks++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall got %0b exp 1", stall); end
    checks++; if (bubble !== 1'b1) begin fails++; $display("FAIL lu_bubble got %0b exp 1", bubble); end
    tick();
    checks++; if (fwd_a_sel !== 2'b00) begin fails++; $display("FAIL lu_bubble_fwd_a got %b exp 00", fwd_a_sel); end
    drive(1, 6'h00, 5'd5, 5'd2, 1, 1, 5'd6, 1);
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_stall_once got %0b exp 0", stall); end
    checks++; if (bubble !== 1'b0) begin fails++; $display("FAIL lu_bubble_once got %0b exp 0", bubble); end
    tick();
    checks++; if (fwd_a_sel !== 2'b10) begin fails++; $display("FAIL lu_fwd_a got %b exp 10", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b00) begin fails++; $display("FAIL lu_fwd_b got %b exp 00", fwd_b_sel); end
    checks++; if (wb_we !== 1'b1) begin fails++; $display("FAIL lu_wb_we got %0b exp 1", wb_we); end
    checks++; if (wb_wreg !== 5'd5) begin fails++; $display("FAIL lu_wb_wreg got %0d exp 5", wb_wreg); end
`ifdef REDIRECT_STATS_EN
    checks++; if (stall_cnt !== 32'd1) begin fails++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt); end
`endif
  endtask

  task automatic test_flush_hazard;
    apply_reset();
    drive(1, 6'h23, 5'd1, 5'd0, 1, 0, 5'd5, 1);   // lw r5
    tick();
    flush = 1'b1;
    drive(1, 6'h00, 5'd8, 5'd5, 1, 1, 5'd7, 1);   // sub r7,r8,r5 with redirect
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL fl_stall got %0b exp 0", stall); end
    checks++; if (bubble !== 1'b1) begin fails++; $display("FAIL fl_bubble got %0b exp 1", bubble); end
    tick();
    flush = 1'b0;
    checks++; if (fwd_b_sel !== 2'b00) begin fails++; $display("FAIL fl_fwd_b got %b exp 00", fwd_b_sel); end
    drive(0, 6'h00, 5'd0, 5'd0, 0, 0, 5'd0, 0);
    tick();
    checks++; if (wb_wreg !== 5'd5) begin fails++; $display("FAIL fl_wb_load got %0d exp 5", wb_wreg); end
    drive(0, 6'h00, 5'd0, 5'd0, 0, 0, 5'd0, 0);
    tick();
    // The flushed sub must reach WB as a no-write bubble.
    checks++; if (wb_we !== 1'b0) begin fails++; $display("FAIL fl_wb_we got %0b exp 0", wb_we); end
  endtask

  task automatic test_r0;
    apply_reset();
    drive(1, 6'h00, 5'd1, 5'd2, 1, 1, 5'd0, 1);   // add r0 (discarded)
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 6'h00, 5'd0, 5'd0, 1, 1, 5'd12, 1);
      tick();
      checks++; if (fwd_a_sel !== 2'b00) begin fails++; $display("FAIL r0_fwd_a d%0d got %b exp 00", i + 1, fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2'b00) begin fails++; $display("FAIL r0_fwd_b d%0d got %b exp 00", i + 1, fwd_b_sel); end
    end
  endtask

  task automatic test_wb_delay_mem_stall;
    apply_reset();
    drive(1, 6'h00, 5'd1, 5'd2, 1, 1, 5'd9, 1);   // add r9
    tick();
    drive(1, 6'h00, 5'd1, 5'd2, 1, 1, 5'd10, 1);  // add r10
    tick();
    drive(1, 6'h00, 5'd10, 5'd2, 1, 1, 5'd11, 1); // add r11,r10,r2
    tick();
    checks++; if (fwd_a_sel !== 2'b01) begin fails++; $display("FAIL ms_pre_fwd_a got %b exp 01", fwd_a_sel); end
    checks++; if (wb_wreg !== 5'd9) begin fails++; $display("FAIL ms_pre_wb_wreg got %0d exp 9", wb_wreg); end
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 6'h00, 5'd9, 5'd1, 1, 1, 5'd13, 1);
      checks++; if (stall !== 1'b0 || bubble !== 1'b0) begin
        fails++; $display("FAIL ms_comb c%0d got stall=%0b bubble=%0b exp 0 0", i, stall, bubble);
      end
      tick();
      checks++; if (fwd_a_sel !== 2'b01 || wb_wreg !== 5'd9 || wb_we !== 1'b1) begin
        fails++;
        $display("FAIL ms_frozen c%0d got fwd_a=%b wb_wreg=%0d wb_we=%0b exp 01 9 1", i, fwd_a_sel, wb_wreg, wb_we);
      end
    end
    mem_stall = 1'b0;
    drive(1, 6'h00, 5'd9, 5'd1, 1, 1, 5'd13, 1);
    tick();
    checks++; if (fwd_a_sel !== 2'b11) begin fails++; $display("FAIL ms_fwd_a got %b exp 11", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b00) begin fails++; $display("FAIL ms_fwd_b got %b exp 00", fwd_b_sel); end
    checks++; if (wb_wreg !== 5'd10) begin fails++; $display("FAIL ms_wb_wreg got %0d exp 10", wb_wreg); end
  endtask

  task automatic test_reset_mid_stall;
    apply_reset();
    drive(1, 6'h23, 5'd1, 5'd0, 1, 0, 5'd5, 1);   // lw r5
    tick();
    drive(1, 6'h00, 5'd5, 5'd2, 1, 1, 5'd6, 1);   // load-use stall
    tick();
    drive(1, 6'h24, 5'd2, 5'd0, 1, 0, 5'd7, 1);   // lbu r7
    tick();
    drive(1, 6'h00, 5'd7, 5'd1, 1, 1, 5'd6, 1);   // add r6,r7,r1
    checks++; if (stall !== 1'b1) begin fails++; $display("FAIL rs_pre_stall got %0b exp 1", stall); end
`ifdef REDIRECT_STATS_EN
    checks++; if (stall_cnt !== 32'd1) begin fails++; $display("FAIL rs_pre_stall_cnt got %0d exp 1", stall_cnt); end
`endif
    rst = 1'b1;
    #1;
    checks++; if (stall !== 1'b0 || bubble !== 1'b0) begin
      fails++; $display("FAIL rs_comb got stall=%0b bubble=%0b exp 0 0", stall, bubble);
    end
    checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || wb_we !== 1'b0 || wb_wreg !== 5'd0) begin
      fails++;
      $display("FAIL rs_regs got a=%b b=%b we=%0b wreg=%0d exp 00 00 0 0", fwd_a_sel, fwd_b_sel, wb_we, wb_wreg);
    end
`ifdef REDIRECT_STATS_EN
    checks++; if (stall_cnt !== 32'd0) begin fails++; $display("FAIL rs_stall_cnt got %0d exp 0", stall_cnt); end
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL rs_post_stall got %0b exp 0", stall); end
    checks++; if (bubble !== 1'b0) begin fails++; $display("FAIL rs_post_bubble got %0b exp 0", bubble); end
    tick();
    checks++; if (fwd_a_sel !== 2'b00) begin fails++; $display("FAIL rs_post_fwd_a got %b exp 00", fwd_a_sel); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_flush_hazard();
    test_r0();
    test_wb_delay_mem_stall();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
